// File: rtl/key_press_classifier.sv
// Key gesture classifier: turns a debounced active-low key level into one-cycle
// short / long / auto-repeat / double-click pulses. Single clock domain.
module key_press_classifier #(
  parameter int unsigned LONG_CYC   = 200_000_000,
  parameter int unsigned GAP_CYC    = 60_000_000,
  parameter int unsigned REPEAT_CYC = 40_000_000,
  parameter int unsigned CNT_W      = 28
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_filter,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic double_pulse,
  output logic key_busy
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StPress1   = 3'd1;
  localparam logic [2:0] StLongHold = 3'd2;
  localparam logic [2:0] StWaitGap  = 3'd3;
  localparam logic [2:0] StPress2   = 3'd4;

  // Terminal counts: each timed state fires when cnt reaches its period minus one.
  localparam logic [CNT_W-1:0] LongLast   = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] GapLast    = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_CYC - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_dly_q;
  logic             press_edge;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             double_q, double_d;
  logic             busy_q;

  // Falling edge of the active-low key; key_dly_q resets to "pressed" so a key
  // held through reset must be released before it can start a gesture.
  assign press_edge = key_dly_q & ~key_filter;

  // Next-state, counter and pulse decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    double_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (press_edge) begin
          state_d = StPress1;
        end
      end
      StPress1: begin
        if (key_filter) begin
          state_d = StWaitGap;
          cnt_d   = '0;
        end else if (cnt_q == LongLast) begin
          state_d = StLongHold;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StLongHold: begin
        if (key_filter) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == RepeatLast) begin
          cnt_d    = '0;
          repeat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitGap: begin
        // A second press wins over a timeout landing in the same cycle.
        if (!key_filter) begin
          state_d = StPress2;
          cnt_d   = '0;
        end else if (cnt_q == GapLast) begin
          state_d = StIdle;
          cnt_d   = '0;
          short_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StPress2: begin
        // Second press length is deliberately untimed.
        cnt_d = '0;
        if (key_filter) begin
          state_d  = StIdle;
          double_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, edge-detect and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      key_dly_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      double_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_dly_q <= key_filter;
      short_q   <= short_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      double_q  <= double_d;
      busy_q    <= (state_d != StIdle);
    end
  end

  assign short_pulse  = short_q;
  assign long_pulse   = long_q;
  assign repeat_pulse = repeat_q;
  assign double_pulse = double_q;
  assign key_busy     = busy_q;

endmodule
